// File: rtl/axi_wr_guard_slave.sv
// AXI4 write-only subordinate over an internal word memory. Every burst is bounded
// (oversize, malformed, WLAST-less or stalled bursts end in SLVERR) and repeated errors lock AW out.
module axi_wr_guard_slave #(
    parameter int                ADDR_W    = 32'd32,
    parameter int                ID_W      = 32'd4,
    parameter int                MEM_WORDS = 32'd1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h4000_0000,
    parameter int                MAX_LEN   = 32'd15,
    parameter int                TIMEOUT   = 32'd256,
    parameter int                ERR_LIMIT = 32'd4,
    parameter int                LOCKOUT   = 32'd1024
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         s_awvalid,
    output logic                         s_awready,
    input  logic [ADDR_W-1:0]            s_awaddr,
    input  logic [7:0]                   s_awlen,
    input  logic [2:0]                   s_awsize,
    input  logic [1:0]                   s_awburst,
    input  logic [ID_W-1:0]              s_awid,
    input  logic                         s_wvalid,
    output logic                         s_wready,
    input  logic [31:0]                  s_wdata,
    input  logic [3:0]                   s_wstrb,
    input  logic                         s_wlast,
    output logic                         s_bvalid,
    input  logic                         s_bready,
    output logic [1:0]                   s_bresp,
    output logic [ID_W-1:0]              s_bid,
    input  logic [$clog2(MEM_WORDS)-1:0] dbg_addr,
    output logic [31:0]                  dbg_data,
    output logic [15:0]                  err_count,
    output logic                         locked
);

    localparam int IDX_W  = $clog2(MEM_WORDS);
    localparam int IDLE_W = $clog2(TIMEOUT + 32'd1);
    localparam int LOCK_W = $clog2(LOCKOUT + 32'd1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [ADDR_W:0] BASE_EXT  = {1'b0, BASE_ADDR};
    localparam logic [ADDR_W:0] LIMIT_EXT = BASE_EXT + (ADDR_W+1)'(32'd4 * MEM_WORDS);

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_RESP, ST_LOCK} state_t;

    state_t              state_r, state_s;
    logic                awready_r, wready_r, bvalid_r, locked_r;
    logic [1:0]          bresp_r;
    logic [ID_W-1:0]     bid_r, id_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [7:0]          len_r, beat_r, consec_r, consec_nxt_s;
    logic                discard_r;
    logic [IDLE_W-1:0]   idle_cnt_r;
    logic [LOCK_W-1:0]   lock_cnt_r;
    logic [15:0]         err_count_r;
    logic [31:0]         dbg_data_r;
    logic [31:0]         mem_r [MEM_WORDS];
    logic                aw_hs_s, w_hs_s, b_hs_s, resp_err_s, mem_we_s;
    logic                aw_bad_s, aw_cross_s;
    logic [ADDR_W:0]     aw_end_s;
    logic [ADDR_W-1:0]   off_s;
    logic [IDX_W-1:0]    widx_s;

    assign s_awready = awready_r;
    assign s_wready  = wready_r;
    assign s_bvalid  = bvalid_r;
    assign s_bresp   = bresp_r;
    assign s_bid     = bid_r;
    assign dbg_data  = dbg_data_r;
    assign err_count = err_count_r;
    assign locked    = locked_r;

    // Handshakes, AW legality check and write-port address decode
    always_comb begin
        aw_hs_s  = s_awvalid && awready_r;
        w_hs_s   = s_wvalid && wready_r;
        b_hs_s   = bvalid_r && s_bready;
        mem_we_s = w_hs_s && !discard_r;
        off_s    = addr_r - BASE_ADDR;
        widx_s   = IDX_W'(off_s >> 2'd2);
        // End address is one past the last beat, so the whole burst must fit below LIMIT_EXT
        aw_end_s   = {1'b0, s_awaddr} + (ADDR_W+1)'({s_awlen, 2'b00}) + (ADDR_W+1)'(3'd4);
        aw_cross_s = ({1'b0, s_awaddr[11:0]} + {3'b000, s_awlen, 2'b00}) > 13'h0FFF;
        aw_bad_s   = (s_awlen > 8'(MAX_LEN)) || (s_awsize != 3'd2) || (s_awburst != 2'd1) ||
                     (s_awaddr[1:0] != 2'b00) || ({1'b0, s_awaddr} < BASE_EXT) ||
                     (aw_end_s > LIMIT_EXT) || aw_cross_s;
        consec_nxt_s = (bresp_r == RESP_SLVERR) ? consec_r + 8'd1 : 8'd0;
    end

    // Next-state logic and the error verdict for the response about to be issued
    always_comb begin
        state_s    = state_r;
        resp_err_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (aw_hs_s) state_s = ST_DATA;
                else         state_s = ST_IDLE;
            end
            ST_DATA: begin
                if (w_hs_s) begin
                    if (beat_r == len_r) begin
                        state_s    = ST_RESP;
                        resp_err_s = discard_r || !s_wlast;
                    end else if (s_wlast) begin
                        state_s    = ST_RESP;
                        resp_err_s = 1'b1;
                    end else begin
                        state_s = ST_DATA;
                    end
                end else if (idle_cnt_r == IDLE_W'(TIMEOUT - 32'd1)) begin
                    state_s    = ST_RESP;
                    resp_err_s = 1'b1;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_RESP: begin
                if (b_hs_s) state_s = (consec_nxt_s >= 8'(ERR_LIMIT)) ? ST_LOCK : ST_IDLE;
                else        state_s = ST_RESP;
            end
            ST_LOCK: begin
                if (lock_cnt_r == LOCK_W'(LOCKOUT - 32'd1)) state_s = ST_IDLE;
                else                                         state_s = ST_LOCK;
            end
            default: begin
                state_s    = ST_IDLE;
                resp_err_s = 1'b0;
            end
        endcase
    end

    // Backing memory: byte-masked writes, deliberately not reset
    always_ff @(posedge clock) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_we_s && s_wstrb[b]) mem_r[widx_s][8*b +: 8] <= s_wdata[8*b +: 8];
        end
    end

    // Control state, burst tracking, registered outputs and error accounting
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            awready_r   <= 1'b0;
            wready_r    <= 1'b0;
            bvalid_r    <= 1'b0;
            locked_r    <= 1'b0;
            bresp_r     <= RESP_OKAY;
            bid_r       <= '0;
            id_r        <= '0;
            addr_r      <= '0;
            len_r       <= 8'd0;
            beat_r      <= 8'd0;
            discard_r   <= 1'b0;
            idle_cnt_r  <= '0;
            lock_cnt_r  <= '0;
            consec_r    <= 8'd0;
            err_count_r <= 16'd0;
            dbg_data_r  <= 32'd0;
        end else begin
            state_r    <= state_s;
            awready_r  <= (state_s == ST_IDLE);
            wready_r   <= (state_s == ST_DATA);
            bvalid_r   <= (state_s == ST_RESP);
            locked_r   <= (state_s == ST_LOCK);
            dbg_data_r <= mem_r[dbg_addr];
            if (aw_hs_s) begin
                id_r       <= s_awid;
                addr_r     <= s_awaddr;
                len_r      <= s_awlen;
                discard_r  <= aw_bad_s;
                beat_r     <= 8'd0;
                idle_cnt_r <= '0;
            end else if (w_hs_s) begin
                addr_r     <= addr_r + ADDR_W'(32'd4);
                beat_r     <= beat_r + 8'd1;
                idle_cnt_r <= '0;
            end else if (state_r == ST_DATA) begin
                idle_cnt_r <= idle_cnt_r + IDLE_W'(1'b1);
            end
            if (state_r == ST_DATA && state_s == ST_RESP) begin
                bid_r   <= id_r;
                bresp_r <= resp_err_s ? RESP_SLVERR : RESP_OKAY;
            end
            if (b_hs_s) begin
                consec_r <= consec_nxt_s;
                if (bresp_r == RESP_SLVERR && err_count_r != 16'hFFFF) err_count_r <= err_count_r + 16'd1;
            end else if (state_r == ST_LOCK && state_s == ST_IDLE) begin
                consec_r <= 8'd0;
            end
            if (state_r == ST_LOCK) lock_cnt_r <= lock_cnt_r + LOCK_W'(1'b1);
            else                    lock_cnt_r <= '0;
        end
    end

endmodule

// File: tb/tb_axi_wr_guard_slave.sv
// Scoreboard bench for axi_wr_guard_slave: expected B responses are queued when a burst is
// issued and popped when B completes; memory is tracked in a word model read back via dbg.
module tb_axi_wr_guard_slave;

    localparam int TIMEOUT = 256;
    localparam int LOCKOUT = 1024;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        s_awvalid = 1'b0, s_awready;
    logic [31:0] s_awaddr = 32'd0;
    logic [7:0]  s_awlen = 8'd0;
    logic [2:0]  s_awsize = 3'd2;
    logic [1:0]  s_awburst = 2'd1;
    logic [3:0]  s_awid = 4'd0;
    logic        s_wvalid = 1'b0, s_wready;
    logic [31:0] s_wdata = 32'd0;
    logic [3:0]  s_wstrb = 4'h0;
    logic        s_wlast = 1'b0;
    logic        s_bvalid, s_bready = 1'b0;
    logic [1:0]  s_bresp;
    logic [3:0]  s_bid;
    logic [9:0]  dbg_addr = 10'd0;
    logic [31:0] dbg_data;
    logic [15:0] err_count;
    logic        locked;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct packed {logic [3:0] id; logic [1:0] resp;} b_exp_t;
    b_exp_t      bq[$];
    logic [31:0] model [0:1023];

    axi_wr_guard_slave dut (
        .clock(clock), .reset(reset),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
        .s_awsize(s_awsize), .s_awburst(s_awburst), .s_awid(s_awid),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp), .s_bid(s_bid),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .err_count(err_count), .locked(locked)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic do_aw(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                         input logic [2:0] size = 3'd2);
        int n = 0;
        s_awaddr = addr; s_awlen = len; s_awid = id; s_awsize = size; s_awburst = 2'd1;
        s_awvalid = 1'b1;
        while (!s_awready && n < 2000) begin @(posedge clock); #1; n++; end
        if (!s_awready) begin
            tests_run++; tests_failed++;
            $display("FAIL aw_wait: awready=%0b after %0d cycles, required 1", s_awready, n);
        end else begin
            @(posedge clock); #1;
        end
        s_awvalid = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n = 0;
        s_wdata = data; s_wstrb = strb; s_wlast = last; s_wvalid = 1'b1;
        while (!s_wready && n < 2000) begin @(posedge clock); #1; n++; end
        if (!s_wready) begin
            tests_run++; tests_failed++;
            $display("FAIL w_wait: wready=%0b after %0d cycles, required 1", s_wready, n);
        end else begin
            @(posedge clock); #1;
        end
        s_wvalid = 1'b0; s_wlast = 1'b0;
    endtask

    task automatic wait_b(input int hold, output logic [3:0] id, output logic [1:0] resp, output bit stable);
        int n = 0;
        stable = 1'b1;
        while (!s_bvalid && n < 2000) begin @(posedge clock); #1; n++; end
        if (!s_bvalid) begin
            tests_run++; tests_failed++;
            $display("FAIL b_wait: bvalid=%0b after %0d cycles, required 1", s_bvalid, n);
            id = 4'd0; resp = 2'b11;
            return;
        end
        id = s_bid; resp = s_bresp;
        for (int i = 0; i < hold; i++) begin
            @(posedge clock); #1;
            if (!s_bvalid || s_bid !== id || s_bresp !== resp) stable = 1'b0;
        end
        s_bready = 1'b1;
        @(posedge clock); #1;
        s_bready = 1'b0;
    endtask

    task automatic rd(input int idx, output logic [31:0] d);
        dbg_addr = 10'(idx);
        @(posedge clock); #1;
        d = dbg_data;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clock);
        #1;
        tests_run++;
        if ({s_awready, s_wready, s_bvalid, s_bresp, s_bid, err_count, locked, dbg_data} !== 58'd0) begin
            tests_failed++;
            $display("FAIL reset_values: aw=%0b w=%0b b=%0b resp=%0b id=%0d err=%0d lock=%0b dbg=%h, required all 0",
                     s_awready, s_wready, s_bvalid, s_bresp, s_bid, err_count, locked, dbg_data);
        end
        reset = 1'b0;
        @(posedge clock); #1;
        tests_run++;
        if (s_awready !== 1'b1 || locked !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: awready=%0b locked=%0b, required 1/0", s_awready, locked);
        end
    endtask

    task automatic test_fill;
        logic [3:0] id; logic [1:0] resp; bit st; b_exp_t e;
        do_aw(32'h4000_0000, 8'd15, 4'd0);
        bq.push_back('{id: 4'd0, resp: OKAY});
        for (int i = 0; i < 16; i++) begin
            do_w(32'h1000_0000 + 32'(i), 4'hF, i == 15);
            model[i] = 32'h1000_0000 + 32'(i);
        end
        wait_b(0, id, resp, st);
        e = bq.pop_front();
        tests_run++;
        if (id !== e.id || resp !== e.resp) begin
            tests_failed++;
            $display("FAIL fill_b: bid=%0d bresp=%0b, required %0d/%0b", id, resp, e.id, e.resp);
        end
    endtask

    task automatic test_t1;
        logic [3:0] id; logic [1:0] resp; bit st; b_exp_t e; logic [31:0] d;
        do_aw(32'h4000_0004, 8'd0, 4'd3);
        bq.push_back('{id: 4'd3, resp: OKAY});
        tests_run++;
        if (s_wready !== 1'b1) begin
            tests_failed++;
            $display("FAIL t1_wready_latency: wready=%0b one cycle after AW, required 1", s_wready);
        end
        do_w(32'hCAFE_0001, 4'hF, 1'b1);
        model[1] = 32'hCAFE_0001;
        tests_run++;
        if (s_bvalid !== 1'b1) begin
            tests_failed++;
            $display("FAIL t1_bvalid_latency: bvalid=%0b one cycle after last W, required 1", s_bvalid);
        end
        wait_b(0, id, resp, st);
        e = bq.pop_front();
        tests_run++;
        if (id !== e.id || resp !== e.resp) begin
            tests_failed++;
            $display("FAIL t1_b: bid=%0d bresp=%0b, required %0d/%0b", id, resp, e.id, e.resp);
        end
        rd(1, d);
        tests_run++;
        if (d !== model[1]) begin
            tests_failed++;
            $display("FAIL t1_mem: word1=%h, required %h", d, model[1]);
        end
    endtask

    task automatic test_strobe;
        logic [3:0] id; logic [1:0] resp; bit st; b_exp_t e; logic [31:0] d;
        do_aw(32'h4000_0008, 8'd0, 4'd4);
        bq.push_back('{id: 4'd4, resp: OKAY});
        do_w(32'h1122_3344, 4'b0101, 1'b1);
        model[2] = {model[2][31:24], 8'h22, model[2][15:8], 8'h44};
        wait_b(0, id, resp, st);
        e = bq.pop_front();
        rd(2, d);
        tests_run++;
        if (id !== e.id || resp !== e.resp || d !== model[2]) begin
            tests_failed++;
            $display("FAIL strobe: bid=%0d bresp=%0b word2=%h, required %0d/%0b/%h", id, resp, d, e.id, e.resp, model[2]);
        end
    endtask

    task automatic test_t2;
        logic [3:0] id; logic [1:0] resp; bit st; b_exp_t e; logic [31:0] d;
        do_aw(32'h4000_0010, 8'd3, 4'd5);
        bq.push_back('{id: 4'd5, resp: OKAY});
        for (int i = 0; i < 4; i++) begin
            do_w(32'h0000_00A0 + 32'(i), 4'hF, i == 3);
            model[4 + i] = 32'h0000_00A0 + 32'(i);
        end
        wait_b(5, id, resp, st);
        e = bq.pop_front();
        tests_run++;
        if (st !== 1'b1) begin
            tests_failed++;
            $display("FAIL t2_b_stable: stable=%0b during 5 stalled cycles, required 1", st);
        end
        tests_run++;
        if (id !== e.id || resp !== e.resp) begin
            tests_failed++;
            $display("FAIL t2_b: bid=%0d bresp=%0b, required %0d/%0b", id, resp, e.id, e.resp);
        end
        tests_run++;
        if (s_bvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL t2_bvalid_drop: bvalid=%0b after handshake, required 0", s_bvalid);
        end
        for (int i = 4; i < 8; i++) begin
            rd(i, d);
            tests_run++;
            if (d !== model[i]) begin
                tests_failed++;
                $display("FAIL t2_mem: word%0d=%h, required %h", i, d, model[i]);
            end
        end
    endtask

    task automatic test_t3_drain;
        logic [3:0] id; logic [1:0] resp; bit st; b_exp_t e; logic [31:0] d;
        int cnt = 0;
        int n = 0;
        do_aw(32'h4000_1000, 8'd255, 4'd7);
        bq.push_back('{id: 4'd7, resp: SLVERR});
        s_wdata = 32'hDEAD_BEEF; s_wstrb = 4'hF; s_wlast = 1'b0; s_wvalid = 1'b1;
        while (!s_bvalid && n < 1000) begin
            if (s_wready) cnt++;
            @(posedge clock); #1; n++;
        end
        s_wvalid = 1'b0;
        tests_run++;
        if (cnt !== 256) begin
            tests_failed++;
            $display("FAIL t3_beats: drained %0d beats, required 256", cnt);
        end
        wait_b(0, id, resp, st);
        e = bq.pop_front();
        tests_run++;
        if (id !== e.id || resp !== e.resp || err_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL t3_b: bid=%0d bresp=%0b err=%0d, required %0d/%0b/1", id, resp, err_count, e.id, e.resp);
        end
        for (int i = 0; i < 16; i++) begin
            rd(i, d);
            tests_run++;
            if (d !== model[i]) begin
                tests_failed++;
                $display("FAIL t3_mem_untouched: word%0d=%h, required %h", i, d, model[i]);
            end
        end
    endtask

    task automatic test_t4_nolast;
        logic [3:0] id; logic [1:0] resp; bit st; b_exp_t e; logic [31:0] d;
        do_aw(32'h4000_0030, 8'd3, 4'd9);
        bq.push_back('{id: 4'd9, resp: SLVERR});
        for (int i = 0; i < 4; i++) begin
            do_w(32'h0000_0C00 + 32'(i), 4'hF, 1'b0);
            model[12 + i] = 32'h0000_0C00 + 32'(i);
        end
        tests_run++;
        if (s_bvalid !== 1'b1 || s_wready !== 1'b0) begin
            tests_failed++;
            $display("FAIL t4_cutoff: bvalid=%0b wready=%0b after beat 4, required 1/0", s_bvalid, s_wready);
        end
        wait_b(0, id, resp, st);
        e = bq.pop_front();
        tests_run++;
        if (id !== e.id || resp !== e.resp || s_wready !== 1'b0) begin
            tests_failed++;
            $display("FAIL t4_b: bid=%0d bresp=%0b wready=%0b, required %0d/%0b/0", id, resp, s_wready, e.id, e.resp);
        end
        for (int i = 12; i < 16; i++) begin
            rd(i, d);
            tests_run++;
            if (d !== model[i]) begin
                tests_failed++;
                $display("FAIL t4_mem: word%0d=%h, required %h", i, d, model[i]);
            end
        end
    endtask

    task automatic test_malformed;
        logic [3:0] id; logic [1:0] resp; bit st; b_exp_t e; logic [31:0] d;
        do_aw(32'h4000_000C, 8'd0, 4'd6, 3'd1);
        bq.push_back('{id: 4'd6, resp: SLVERR});
        do_w(32'h5555_AAAA, 4'hF, 1'b1);
        wait_b(0, id, resp, st);
        e = bq.pop_front();
        rd(3, d);
        tests_run++;
        if (id !== e.id || resp !== e.resp || d !== model[3] || err_count !== 16'd3) begin
            tests_failed++;
            $display("FAIL malformed: bid=%0d bresp=%0b word3=%h err=%0d, required %0d/%0b/%h/3",
                     id, resp, d, err_count, e.id, e.resp, model[3]);
        end
    endtask

    task automatic test_timeout_race;
        logic [3:0] id; logic [1:0] resp; bit st; b_exp_t e; logic [31:0] d;
        do_aw(32'h4000_0020, 8'd1, 4'd8);
        bq.push_back('{id: 4'd8, resp: OKAY});
        repeat (TIMEOUT - 1) begin @(posedge clock); #1; end
        tests_run++;
        if (s_bvalid !== 1'b0 || s_wready !== 1'b1) begin
            tests_failed++;
            $display("FAIL race_pre: bvalid=%0b wready=%0b after %0d idle cycles, required 0/1", s_bvalid, s_wready, TIMEOUT - 1);
        end
        do_w(32'h0000_0B00, 4'hF, 1'b0);
        model[8] = 32'h0000_0B00;
        tests_run++;
        if (s_bvalid !== 1'b0 || s_wready !== 1'b1) begin
            tests_failed++;
            $display("FAIL race_beat: bvalid=%0b wready=%0b after beat on timeout cycle, required 0/1", s_bvalid, s_wready);
        end
        do_w(32'h0000_0B01, 4'hF, 1'b1);
        model[9] = 32'h0000_0B01;
        wait_b(0, id, resp, st);
        e = bq.pop_front();
        tests_run++;
        if (id !== e.id || resp !== e.resp) begin
            tests_failed++;
            $display("FAIL race_b: bid=%0d bresp=%0b, required %0d/%0b", id, resp, e.id, e.resp);
        end
        for (int i = 8; i < 10; i++) begin
            rd(i, d);
            tests_run++;
            if (d !== model[i]) begin
                tests_failed++;
                $display("FAIL race_mem: word%0d=%h, required %h", i, d, model[i]);
            end
        end
    endtask

    task automatic test_t5_lockout;
        logic [3:0] id; logic [1:0] resp; bit st; b_exp_t e;
        int n;
        bit leak;
        for (int k = 0; k < 4; k++) begin
            do_aw(32'h4000_0000, 8'd0, 4'd1);
            bq.push_back('{id: 4'd1, resp: SLVERR});
            n = 0;
            while (!s_bvalid && n < 1000) begin @(posedge clock); #1; n++; end
            if (k == 0) begin
                // bvalid is seen after the TIMEOUT-th edge, i.e. in cycle TIMEOUT+1 of DATA
                tests_run++;
                if (n !== TIMEOUT) begin
                    tests_failed++;
                    $display("FAIL t5_timeout_latency: bvalid after %0d cycles, required %0d", n, TIMEOUT);
                end
            end
            wait_b(0, id, resp, st);
            e = bq.pop_front();
            tests_run++;
            if (id !== e.id || resp !== e.resp || locked !== (k == 3)) begin
                tests_failed++;
                $display("FAIL t5_b%0d: bid=%0d bresp=%0b locked=%0b, required %0d/%0b/%0b",
                         k, id, resp, locked, e.id, e.resp, k == 3);
            end
        end
        tests_run++;
        if (err_count !== 16'd7) begin
            tests_failed++;
            $display("FAIL t5_err_count: err_count=%0d, required 7", err_count);
        end
        s_awaddr = 32'h4000_0004; s_awlen = 8'd0; s_awid = 4'd3; s_awsize = 3'd2; s_awvalid = 1'b1;
        n = 0; leak = 1'b0;
        while (locked && n < 2000) begin
            if (s_awready || s_wready) leak = 1'b1;
            @(posedge clock); #1; n++;
        end
        s_awvalid = 1'b0;
        tests_run++;
        if (n !== LOCKOUT || leak !== 1'b0) begin
            tests_failed++;
            $display("FAIL t5_lock: locked for %0d cycles leak=%0b, required %0d/0", n, leak, LOCKOUT);
        end
        tests_run++;
        if (s_awready !== 1'b1) begin
            tests_failed++;
            $display("FAIL t5_unlock: awready=%0b after lockout, required 1", s_awready);
        end
        test_t1();
    endtask

    task automatic test_t6_reset_mid;
        logic [31:0] d;
        do_aw(32'h4000_0040, 8'd3, 4'd2);
        for (int i = 0; i < 2; i++) begin
            do_w(32'h0000_1600 + 32'(i), 4'hF, 1'b0);
            model[16 + i] = 32'h0000_1600 + 32'(i);
        end
        s_wdata = 32'h0000_1602; s_wstrb = 4'hF; s_wlast = 1'b0; s_wvalid = 1'b1;
        #4;
        reset = 1'b1;
        #1;
        tests_run++;
        if ({s_awready, s_wready, s_bvalid, s_bresp, s_bid, err_count, locked, dbg_data} !== 58'd0) begin
            tests_failed++;
            $display("FAIL t6_async_reset: aw=%0b w=%0b b=%0b resp=%0b id=%0d err=%0d lock=%0b dbg=%h, required all 0",
                     s_awready, s_wready, s_bvalid, s_bresp, s_bid, err_count, locked, dbg_data);
        end
        s_wvalid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock); #1;
        tests_run++;
        if (s_awready !== 1'b1 || s_bvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL t6_after_reset: awready=%0b bvalid=%0b, required 1/0", s_awready, s_bvalid);
        end
        for (int i = 16; i < 18; i++) begin
            rd(i, d);
            tests_run++;
            if (d !== model[i]) begin
                tests_failed++;
                $display("FAIL t6_mem_kept: word%0d=%h, required %h", i, d, model[i]);
            end
        end
        test_t1();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_t1();
        test_strobe();
        test_t2();
        test_t3_drain();
        test_t4_nolast();
        test_malformed();
        test_timeout_race();
        test_t5_lockout();
        test_t6_reset_mid();
        tests_run++;
        if (bq.size() !== 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", bq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
